// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage with variable-latency data memory request/response channels
// Accepts EX/MEM payloads, performs loads/stores, and presents a registered MEM/WB payload.
module mem_access_unit #(
   parameter int XLEN    = 32,
   parameter int REG_AW  = 5,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   alu_result,
   input  logic [XLEN-1:0]   store_data,
   input  logic [XLEN-1:0]   pc_plus4,
   input  logic [REG_AW-1:0] rd,
   input  logic              Mem_Write,
   input  logic              Mem_Read,
   input  logic              Reg_write,
   input  logic [1:0]        Result_src,
   input  logic [1:0]        Store_type,
   input  logic [2:0]        Load_type,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   mem_read_data,
   output logic [XLEN-1:0]   alu_result_wb,
   output logic [XLEN-1:0]   pc_plus4_wb,
   output logic [REG_AW-1:0] rd_wb,
   output logic              Reg_write_wb,
   output logic [1:0]        Result_src_wb,
   output logic              misalign_exc,
   output logic              bus_err_exc,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic [XLEN-1:0]   dmem_addr,
   output logic              dmem_we,
   output logic [XLEN/8-1:0] dmem_wstrb,
   output logic [XLEN-1:0]   dmem_wdata,
   input  logic              dmem_rsp_valid,
   input  logic [XLEN-1:0]   dmem_rdata
);
   localparam int SB = XLEN / 8;
   localparam int OW = $clog2(SB);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t            state;
   logic [TW-1:0]     tcnt;
   logic              req_taken, rsp_got;
   logic [XLEN-1:0]   skid_q;
   logic              lat_store, lat_rw;
   logic [2:0]        lat_lt;
   logic [XLEN-1:0]   lat_pc;
   logic [REG_AW-1:0] lat_rd;
   logic [1:0]        lat_rs;

   logic              can_out, accept, is_mem, misalign, req_hs, timed_out, rsp_have;
   logic [1:0]        acc_size;
   logic [7:0]        size_mask;
   logic [SB-1:0]     wstrb_next;
   logic [XLEN-1:0]   wdata_next, rsp_data, ld_shift, ld_data;

   logic              done, d_rw, d_mis, d_bus;
   logic [XLEN-1:0]   d_data, d_alu, d_pc;
   logic [REG_AW-1:0] d_rd;
   logic [1:0]        d_rs;

   assign can_out        = !out_valid || out_ready;
   assign in_ready       = (state == IDLE) && can_out;
   assign accept         = in_valid && in_ready;
   assign is_mem         = Mem_Read || Mem_Write;
   assign acc_size       = Mem_Write ? Store_type : Load_type[1:0];
   assign dmem_req_valid = (state == REQ) && !req_taken;
   assign req_hs         = dmem_req_valid && dmem_req_ready;
   assign timed_out      = (tcnt == TW'(TIMEOUT - 1));
   assign rsp_have       = rsp_got || dmem_rsp_valid;
   assign rsp_data       = rsp_got ? skid_q : dmem_rdata;
   assign ld_shift       = rsp_data >> {dmem_addr[OW-1:0], 3'b000};
   assign wstrb_next     = SB'(size_mask) << alu_result[OW-1:0];

   always_comb begin
      misalign  = 1'b0;
      size_mask = 8'h01;
      case (acc_size)
         2'b01: begin misalign = alu_result[0];      size_mask = 8'h03; end
         2'b10: begin misalign = |alu_result[1:0];   size_mask = 8'h0F; end
         2'b11: begin misalign = |alu_result[2:0];   size_mask = 8'hFF; end
         default: ;
      endcase
   end

   always_comb begin
      case (Store_type)
         2'b00:   wdata_next = {SB{store_data[7:0]}};
         2'b01:   wdata_next = {(SB/2){store_data[15:0]}};
         2'b10:   wdata_next = {(SB/4){store_data[31:0]}};
         default: wdata_next = store_data;
      endcase
   end

   always_comb begin
      case (lat_lt)
         3'b000:  ld_data = XLEN'($signed(ld_shift[7:0]));
         3'b001:  ld_data = XLEN'($signed(ld_shift[15:0]));
         3'b010:  ld_data = XLEN'($signed(ld_shift[31:0]));
         3'b100:  ld_data = XLEN'(ld_shift[7:0]);
         3'b101:  ld_data = XLEN'(ld_shift[15:0]);
         3'b110:  ld_data = XLEN'(ld_shift[31:0]);
         default: ld_data = ld_shift;
      endcase
   end

   // Completion decision: any path that loads the MEM/WB register this cycle.
   always_comb begin
      done   = 1'b0;
      d_data = '0;
      d_alu  = dmem_addr;
      d_pc   = lat_pc;
      d_rd   = lat_rd;
      d_rw   = lat_rw;
      d_rs   = lat_rs;
      d_mis  = 1'b0;
      d_bus  = 1'b0;
      case (state)
         IDLE: if (accept && (!is_mem || misalign)) begin
            done  = 1'b1;
            d_alu = alu_result;
            d_pc  = pc_plus4;
            d_rd  = rd;
            d_rs  = Result_src;
            d_rw  = Reg_write && !is_mem;
            d_mis = is_mem;
         end
         REQ: if (lat_store && (req_taken || req_hs) && can_out) begin
            done = 1'b1;
         end else if (!(req_taken || req_hs) && timed_out && can_out) begin
            done  = 1'b1;
            d_rw  = 1'b0;
            d_bus = 1'b1;
         end
         WAIT: if (rsp_have && can_out) begin
            done   = 1'b1;
            d_data = ld_data;
         end else if (!rsp_have && timed_out && can_out) begin
            done  = 1'b1;
            d_rw  = 1'b0;
            d_bus = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         tcnt          <= '0;
         req_taken     <= 1'b0;
         rsp_got       <= 1'b0;
         skid_q        <= '0;
         lat_store     <= 1'b0;
         lat_rw        <= 1'b0;
         lat_lt        <= '0;
         lat_pc        <= '0;
         lat_rd        <= '0;
         lat_rs        <= '0;
         dmem_addr     <= '0;
         dmem_we       <= 1'b0;
         dmem_wstrb    <= '0;
         dmem_wdata    <= '0;
         out_valid     <= 1'b0;
         mem_read_data <= '0;
         alu_result_wb <= '0;
         pc_plus4_wb   <= '0;
         rd_wb         <= '0;
         Reg_write_wb  <= 1'b0;
         Result_src_wb <= '0;
         misalign_exc  <= 1'b0;
         bus_err_exc   <= 1'b0;
      end else begin
         if (done) begin
            out_valid     <= 1'b1;
            mem_read_data <= d_data;
            alu_result_wb <= d_alu;
            pc_plus4_wb   <= d_pc;
            rd_wb         <= d_rd;
            Reg_write_wb  <= d_rw;
            Result_src_wb <= d_rs;
            misalign_exc  <= d_mis;
            bus_err_exc   <= d_bus;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            IDLE: if (accept && is_mem && !misalign) begin
               dmem_addr  <= alu_result;
               dmem_we    <= Mem_Write;
               dmem_wstrb <= Mem_Write ? wstrb_next : '0;
               dmem_wdata <= Mem_Write ? wdata_next : '0;
               lat_store  <= Mem_Write;
               lat_lt     <= Load_type;
               lat_pc     <= pc_plus4;
               lat_rd     <= rd;
               lat_rw     <= Reg_write;
               lat_rs     <= Result_src;
               tcnt       <= '0;
               req_taken  <= 1'b0;
               rsp_got    <= 1'b0;
               state      <= REQ;
            end
            REQ: if (done) begin
               state <= IDLE;
            end else begin
               if (req_hs) begin
                  req_taken <= 1'b1;
                  if (!lat_store) state <= WAIT;
               end
               if (!timed_out) tcnt <= tcnt + 1'b1;
            end
            WAIT: if (done) begin
               state <= IDLE;
            end else begin
               // Output register busy: park the response so it is not lost.
               if (dmem_rsp_valid && !rsp_got) begin
                  rsp_got <= 1'b1;
                  skid_q  <= dmem_rdata;
               end
               if (!timed_out) tcnt <= tcnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] alu_result, store_data, pc_plus4;
   logic [4:0]  rd;
   logic        Mem_Write, Mem_Read, Reg_write;
   logic [1:0]  Result_src, Store_type;
   logic [2:0]  Load_type;
   logic        out_valid, out_ready;
   logic [31:0] mem_read_data, alu_result_wb, pc_plus4_wb;
   logic [4:0]  rd_wb;
   logic        Reg_write_wb;
   logic [1:0]  Result_src_wb;
   logic        misalign_exc, bus_err_exc;
   logic        dmem_req_valid, dmem_req_ready;
   logic [31:0] dmem_addr;
   logic        dmem_we;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   mem_access_unit #(.XLEN(32), .REG_AW(5), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_result(alu_result), .store_data(store_data), .pc_plus4(pc_plus4), .rd(rd),
      .Mem_Write(Mem_Write), .Mem_Read(Mem_Read), .Reg_write(Reg_write),
      .Result_src(Result_src), .Store_type(Store_type), .Load_type(Load_type),
      .out_valid(out_valid), .out_ready(out_ready), .mem_read_data(mem_read_data),
      .alu_result_wb(alu_result_wb), .pc_plus4_wb(pc_plus4_wb), .rd_wb(rd_wb),
      .Reg_write_wb(Reg_write_wb), .Result_src_wb(Result_src_wb),
      .misalign_exc(misalign_exc), .bus_err_exc(bus_err_exc),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
      .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic [31:0] pc,
                        input logic mw, input logic mr, input logic rw,
                        input logic [1:0] st, input logic [2:0] lt, input logic [4:0] r);
      alu_result = a; store_data = sd; pc_plus4 = pc;
      Mem_Write = mw; Mem_Read = mr; Reg_write = rw;
      Store_type = st; Load_type = lt; rd = r;
      in_valid = 1'b1;
      check("in_ready_at_issue", in_ready, 1);
      step();
      in_valid = 1'b0; Mem_Write = 1'b0; Mem_Read = 1'b0; Reg_write = 1'b0;
   endtask

   logic [31:0] st_addr [3];
   logic [31:0] st_wd   [3];
   logic [1:0]  st_ty   [3];
   logic [3:0]  st_strb [3];
   logic [31:0] ld_addr [4];
   logic [2:0]  ld_ty   [4];
   logic [31:0] ld_rd   [4];
   logic [31:0] ld_exp  [4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      st_addr = '{32'h1003, 32'h1002, 32'h1004};
      st_ty   = '{2'b00, 2'b01, 2'b10};
      st_strb = '{4'b1000, 4'b1100, 4'b1111};
      st_wd   = '{32'hDDDDDDDD, 32'hCCDDCCDD, 32'hAABBCCDD};
      ld_addr = '{32'h1003, 32'h1001, 32'h2002, 32'h3000};
      ld_ty   = '{3'b100, 3'b000, 3'b101, 3'b010};
      ld_rd   = '{32'hDD000000, 32'h00008000, 32'h80010000, 32'hCAFEF00D};
      ld_exp  = '{32'h000000DD, 32'hFFFFFF80, 32'h00008001, 32'hCAFEF00D};

      rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; store_data = '0; pc_plus4 = '0;
      rd = '0; Mem_Write = 1'b0; Mem_Read = 1'b0; Reg_write = 1'b0; Result_src = '0;
      Store_type = '0; Load_type = '0; out_ready = 1'b1;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_req_valid", dmem_req_valid, 0);
      check("rst_wstrb", dmem_wstrb, 0);
      check("rst_rdata", mem_read_data, 0);
      check("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      step();

      // ALU pass-through, one-cycle latency
      Result_src = 2'b10;
      issue(32'h1234, 0, 32'h104, 0, 0, 1, 2'b00, 3'b000, 5);
      check("alu_out_valid", out_valid, 1);
      check("alu_result_wb", alu_result_wb, 32'h1234);
      check("alu_rd_wb", rd_wb, 5);
      check("alu_reg_write", Reg_write_wb, 1);
      check("alu_pc4", pc_plus4_wb, 32'h104);
      check("alu_result_src", Result_src_wb, 2'b10);
      check("alu_no_req", dmem_req_valid, 0);
      step();
      check("alu_out_drop", out_valid, 0);

      for (int i = 0; i < 3; i++) begin
         issue(st_addr[i], 32'hAABBCCDD, 0, 1, 0, 0, st_ty[i], 3'b000, 0);
         check("st_req_valid", dmem_req_valid, 1);
         check("st_we", dmem_we, 1);
         check("st_addr", dmem_addr, st_addr[i]);
         check("st_wstrb", dmem_wstrb, st_strb[i]);
         check("st_wdata", dmem_wdata, st_wd[i]);
         check("st_in_ready", in_ready, 0);
         dmem_req_ready = 1'b1;
         step();
         dmem_req_ready = 1'b0;
         check("st_out_valid", out_valid, 1);
         check("st_req_drop", dmem_req_valid, 0);
         check("st_rdata_zero", mem_read_data, 0);
         step();
      end

      for (int i = 0; i < 4; i++) begin
         issue(ld_addr[i], 0, 0, 0, 1, 1, 2'b00, ld_ty[i], 7);
         check("ld_req_valid", dmem_req_valid, 1);
         check("ld_we", dmem_we, 0);
         dmem_req_ready = 1'b1;
         step();
         dmem_req_ready = 1'b0;
         check("ld_req_drop", dmem_req_valid, 0);
         check("ld_not_yet", out_valid, 0);
         dmem_rsp_valid = 1'b1; dmem_rdata = ld_rd[i];
         step();
         dmem_rsp_valid = 1'b0;
         check("ld_out_valid", out_valid, 1);
         check("ld_data", mem_read_data, ld_exp[i]);
         check("ld_reg_write", Reg_write_wb, 1);
         step();
      end

      // LH with request held off for 5 cycles
      issue(32'h2002, 0, 0, 0, 1, 1, 2'b00, 3'b001, 9);
      for (int i = 0; i < 5; i++) begin
         check("lh_stall_in_ready", in_ready, 0);
         check("lh_stall_req", dmem_req_valid, 1);
         check("lh_stall_addr", dmem_addr, 32'h2002);
         step();
      end
      dmem_req_ready = 1'b1;
      step();
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b1; dmem_rdata = 32'h80010000;
      step();
      dmem_rsp_valid = 1'b0;
      check("lh_out_valid", out_valid, 1);
      check("lh_data", mem_read_data, 32'hFFFF8001);
      check("lh_no_bus_err", bus_err_exc, 0);
      step();

      // Misaligned LW
      issue(32'h3001, 0, 0, 0, 1, 1, 2'b00, 3'b010, 4);
      check("mis_out_valid", out_valid, 1);
      check("mis_exc", misalign_exc, 1);
      check("mis_reg_write", Reg_write_wb, 0);
      check("mis_no_req", dmem_req_valid, 0);
      check("mis_no_bus_err", bus_err_exc, 0);
      step();
      check("mis_no_req_after", dmem_req_valid, 0);
      check("mis_out_drop", out_valid, 0);

      // Timeout: request accepted, response never comes
      issue(32'h4000, 0, 0, 0, 1, 1, 2'b00, 3'b010, 6);
      dmem_req_ready = 1'b1;
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
         if (n == 1) dmem_req_ready = 1'b0;
      end
      check("to_cycles", n, 8);
      check("to_bus_err", bus_err_exc, 1);
      check("to_reg_write", Reg_write_wb, 0);
      check("to_misalign", misalign_exc, 0);
      dmem_rsp_valid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
      step();
      dmem_rsp_valid = 1'b0;
      check("late_rsp_out_valid", out_valid, 0);
      check("late_rsp_req", dmem_req_valid, 0);
      check("late_rsp_in_ready", in_ready, 1);
      step();
      check("late_rsp_ignored", out_valid, 0);

      // Output held while WB stalls
      issue(32'h5004, 0, 0, 0, 1, 1, 2'b00, 3'b010, 10);
      dmem_req_ready = 1'b1;
      step();
      dmem_req_ready = 1'b0;
      out_ready = 1'b0;
      dmem_rsp_valid = 1'b1; dmem_rdata = 32'h12345678;
      step();
      dmem_rsp_valid = 1'b0; dmem_rdata = '0;
      for (int i = 0; i < 3; i++) begin
         check("hold_out_valid", out_valid, 1);
         check("hold_data", mem_read_data, 32'h12345678);
         check("hold_rd", rd_wb, 10);
         check("hold_in_ready", in_ready, 0);
         step();
      end
      out_ready = 1'b1;
      check("hold_still_valid", out_valid, 1);
      step();
      check("hold_released", out_valid, 0);

      // Async reset while in WAIT
      issue(32'h6000, 0, 0, 0, 1, 1, 2'b00, 3'b010, 11);
      dmem_req_ready = 1'b1;
      step();
      dmem_req_ready = 1'b0;
      check("wait_addr", dmem_addr, 32'h6000);
      #2 rst_n = 1'b0;
      #1;
      check("rst_wait_out_valid", out_valid, 0);
      check("rst_wait_addr", dmem_addr, 0);
      check("rst_wait_alu_wb", alu_result_wb, 0);
      check("rst_wait_rdata", mem_read_data, 0);
      check("rst_wait_rd_wb", rd_wb, 0);
      check("rst_wait_in_ready", in_ready, 1);
      rst_n = 1'b1;
      step();

      // Async reset while request is pending
      issue(32'h7000, 0, 0, 0, 1, 1, 2'b00, 3'b010, 12);
      check("req_before_rst", dmem_req_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_req_drop", dmem_req_valid, 0);
      check("rst_req_we", dmem_we, 0);
      rst_n = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
